// File: rtl/regfile_pkg.sv
// Shared types, default reset image and reset-value helper for the regfile_mp register file.
package regfile_pkg;

  localparam int RF_WIDTH_DEF = 8;
  localparam int RF_DEPTH_DEF = 4;
  localparam int RF_AW_DEF    = $clog2(RF_DEPTH_DEF);
  localparam int RF_MAX_WIDTH = 64;
  localparam int RF_MAX_IMAGE = 4096;

  localparam logic [RF_DEPTH_DEF*RF_WIDTH_DEF-1:0] RF_RESET_VALS_DEF = {8'd0, 8'd2, 8'd1, 8'd0};

  typedef struct packed {
    logic                    en;
    logic [RF_AW_DEF-1:0]    addr;
    logic [RF_WIDTH_DEF-1:0] data;
  } wr_req_t;

  // Image is zero-extended to RF_MAX_IMAGE so any WIDTH/DEPTH combination fits one signature.
  function automatic logic [RF_MAX_WIDTH-1:0] regfile_reset_val(
    input logic [RF_MAX_IMAGE-1:0] image,
    input int unsigned             idx,
    input int unsigned             width
  );
    logic [RF_MAX_IMAGE-1:0] shifted;
    logic [RF_MAX_WIDTH-1:0] mask;
    shifted = image >> (idx * width);
    mask    = ~({RF_MAX_WIDTH{1'b1}} << width);
    return shifted[RF_MAX_WIDTH-1:0] & mask;
  endfunction

endpackage

// File: rtl/regfile_mp_rd_port.sv
// One registered read port: write-through bypass (port 1 > port 0 > array) and rd_data/rd_valid flops.
// With REGFILE_ZERO_REG_EN defined, address 0 always reads as zero.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter  int WIDTH = RF_WIDTH_DEF,
  parameter  int DEPTH = RF_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   async_rst,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  input  logic [DEPTH*WIDTH-1:0] regs_flat,
  input  logic [1:0]             wr_en,
  input  logic [2*AW-1:0]        wr_addr,
  input  logic [2*WIDTH-1:0]     wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid
);

  logic [WIDTH-1:0] next_data;

  always_comb begin
    next_data = regs_flat[rd_addr*WIDTH +: WIDTH];
    if (wr_en[0] && (wr_addr[0 +: AW] == rd_addr)) next_data = wr_data[0 +: WIDTH];
    if (wr_en[1] && (wr_addr[AW +: AW] == rd_addr)) next_data = wr_data[WIDTH +: WIDTH];
`ifdef REGFILE_ZERO_REG_EN
    if (rd_addr == '0) next_data = '0;
`endif
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= next_data;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD registered read ports, two write ports, bypass and collision flag.
// Optional REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int                     WIDTH      = RF_WIDTH_DEF,
  parameter  int                     DEPTH      = RF_DEPTH_DEF,
  parameter  int                     NUM_RD     = 2,
  parameter  logic [DEPTH*WIDTH-1:0] RESET_VALS = (DEPTH*WIDTH)'(RF_RESET_VALS_DEF),
  localparam int                     AW         = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    async_rst,
  input  logic [NUM_RD-1:0]       rd_en,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_valid,
  input  logic [1:0]              wr_en,
  input  logic [2*AW-1:0]         wr_addr,
  input  logic [2*WIDTH-1:0]      wr_data,
  output logic                    wr_collision
);

  localparam logic [RF_MAX_IMAGE-1:0] RESET_IMG = RF_MAX_IMAGE'(RESET_VALS);

  logic [WIDTH-1:0]       regs [DEPTH];
  logic [DEPTH*WIDTH-1:0] regs_flat;

  // Port 1 is applied last so it wins a same-address double write.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= WIDTH'(regfile_reset_val(RESET_IMG, i, WIDTH));
      end
`ifdef REGFILE_ZERO_REG_EN
      regs[0] <= '0;
`endif
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (wr_en[k]) regs[wr_addr[k*AW +: AW]] <= wr_data[k*WIDTH +: WIDTH];
      end
`ifdef REGFILE_ZERO_REG_EN
      regs[0] <= '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) wr_collision <= 1'b0;
    else           wr_collision <= wr_en[0] & wr_en[1] & (wr_addr[0 +: AW] == wr_addr[AW +: AW]);
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < DEPTH; i++) regs_flat[i*WIDTH +: WIDTH] = regs[i];
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_rd_port (
      .clk       (clk),
      .async_rst (async_rst),
      .rd_en     (rd_en[p]),
      .rd_addr   (rd_addr[p*AW +: AW]),
      .regs_flat (regs_flat),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_data   (rd_data[p*WIDTH +: WIDTH]),
      .rd_valid  (rd_valid[p])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp at default parameters; honours REGFILE_ZERO_REG_EN when defined.
module tb_regfile_mp;

  logic        clk;
  logic        async_rst;
  logic [1:0]  rd_en;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic [1:0]  rd_valid;
  logic [1:0]  wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_collision;

  typedef struct {
    int         port;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model [4];
  int         checks;
  int         failures;

  regfile_mp dut (
    .clk          (clk),
    .async_rst    (async_rst),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_collision (wr_collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] expect_rd(input logic [1:0] a);
    logic [7:0] v;
    v = model[a];
    if (wr_en[0] && wr_addr[1:0] == a) v = wr_data[7:0];
    if (wr_en[1] && wr_addr[3:2] == a) v = wr_data[15:8];
`ifdef REGFILE_ZERO_REG_EN
    if (a == 2'd0) v = 8'h00;
`endif
    return v;
  endfunction

  task automatic model_reset();
    model[0] = 8'd0; model[1] = 8'd1; model[2] = 8'd2; model[3] = 8'd0;
    sb.delete();
  endtask

  task automatic idle();
    rd_en = 2'b00; wr_en = 2'b00;
  endtask

  // Record expected read results for the driven inputs, update the model, then cross the edge.
  task automatic step();
    for (int p = 0; p < 2; p++)
      if (rd_en[p]) sb.push_back('{port: p, data: expect_rd(rd_addr[p*2 +: 2])});
    if (wr_en[0]) model[wr_addr[1:0]] = wr_data[7:0];
    if (wr_en[1]) model[wr_addr[3:2]] = wr_data[15:8];
`ifdef REGFILE_ZERO_REG_EN
    model[0] = 8'h00;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    idle();
    repeat (2) @(posedge clk);
    #1 async_rst = 1'b0;
    model_reset();
    rd_en = 2'b11; rd_addr = {2'd1, 2'd2};
    wr_en = 2'b11; wr_addr = {2'd3, 2'd3}; wr_data = {8'h88, 8'h77};
    step();
    idle();
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (rd_data[e.port*8 +: 8] !== e.data || rd_valid[e.port] !== 1'b1) begin
        failures++;
        $display("FAIL pre_reset_read port%0d: got data=%h valid=%b, want data=%h valid=1", e.port, rd_data[e.port*8 +: 8], rd_valid[e.port], e.data);
      end
    end
    checks++;
    if (wr_collision !== 1'b1) begin
      failures++; $display("FAIL pre_reset_collision: got %b want 1", wr_collision);
    end
    #2 async_rst = 1'b1;
    #1;
    checks++;
    if (rd_data !== 16'h0 || rd_valid !== 2'b00 || wr_collision !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_outputs: got data=%h valid=%b col=%b want 0/0/0", rd_data, rd_valid, wr_collision);
    end
    model_reset();
    @(posedge clk);
    #1 async_rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      rd_en = 2'b11;
      rd_addr = (c == 0) ? {2'd1, 2'd0} : {2'd3, 2'd2};
      step();
      while (sb.size() > 0) begin
        e = sb.pop_front(); checks++;
        if (rd_data[e.port*8 +: 8] !== e.data || rd_valid[e.port] !== 1'b1) begin
          failures++;
          $display("FAIL reset_image port%0d: got data=%h valid=%b, want data=%h valid=1", e.port, rd_data[e.port*8 +: 8], rd_valid[e.port], e.data);
        end
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    exp_t e;
    wr_en = 2'b01; wr_addr = {2'd0, 2'd2}; wr_data = {8'h00, 8'hA5};
    step();
    idle();
    rd_en = 2'b11; rd_addr = {2'd2, 2'd2};
    step();
    idle();
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (rd_data[e.port*8 +: 8] !== e.data || rd_valid[e.port] !== 1'b1) begin
        failures++;
        $display("FAIL write_read port%0d: got data=%h valid=%b, want data=%h valid=1", e.port, rd_data[e.port*8 +: 8], rd_valid[e.port], e.data);
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) begin
        wr_en = 2'b01; wr_addr = {2'd0, 2'd3}; wr_data = {8'h00, 8'h3C};
        rd_en = 2'b11; rd_addr = {2'd3, 2'd3};
      end else begin
        wr_en = 2'b11; wr_addr = {2'd2, 2'd0}; wr_data = {8'h6B, 8'h5A};
        rd_en = 2'b11; rd_addr = {2'd2, 2'd0};
      end
      step();
      idle();
      while (sb.size() > 0) begin
        e = sb.pop_front(); checks++;
        if (rd_data[e.port*8 +: 8] !== e.data || rd_valid[e.port] !== 1'b1) begin
          failures++;
          $display("FAIL bypass%0d port%0d: got data=%h valid=%b, want data=%h valid=1", c, e.port, rd_data[e.port*8 +: 8], rd_valid[e.port], e.data);
        end
      end
      checks++;
      if (wr_collision !== 1'b0) begin
        failures++; $display("FAIL bypass%0d_no_collision: got %b want 0", c, wr_collision);
      end
    end
  endtask

  task automatic test_collision();
    exp_t e;
    wr_en = 2'b11; wr_addr = {2'd1, 2'd1}; wr_data = {8'h22, 8'h11};
    rd_en = 2'b01; rd_addr = {2'd0, 2'd1};
    step();
    idle();
    checks++;
    if (wr_collision !== 1'b1) begin
      failures++; $display("FAIL collision_flag: got %b want 1", wr_collision);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (rd_data[e.port*8 +: 8] !== e.data || rd_valid[e.port] !== 1'b1) begin
        failures++;
        $display("FAIL collision_bypass port%0d: got data=%h valid=%b, want data=%h valid=1", e.port, rd_data[e.port*8 +: 8], rd_valid[e.port], e.data);
      end
    end
    rd_en = 2'b10; rd_addr = {2'd1, 2'd0};
    step();
    idle();
    checks++;
    if (wr_collision !== 1'b0) begin
      failures++; $display("FAIL collision_one_cycle: got %b want 0", wr_collision);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (rd_data[e.port*8 +: 8] !== e.data || e.data !== 8'h22) begin
        failures++;
        $display("FAIL collision_winner port%0d: got data=%h, want data=22 (model %h)", e.port, rd_data[e.port*8 +: 8], e.data);
      end
    end
  endtask

  task automatic test_hold();
    exp_t       e;
    logic [7:0] held;
    held = 8'h00;
    rd_en = 2'b01; rd_addr = {2'd0, 2'd2};
    step();
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++; held = e.data;
      if (rd_data[7:0] !== e.data || rd_valid[0] !== 1'b1) begin
        failures++;
        $display("FAIL hold_setup: got data=%h valid=%b, want data=%h valid=1", rd_data[7:0], rd_valid[0], e.data);
      end
    end
    for (int i = 0; i < 3; i++) begin
      rd_en = 2'b00;
      wr_en = 2'b01; wr_addr = {2'd0, 2'd2}; wr_data = {8'h00, 8'h40 + 8'(i)};
      step();
      checks++;
      if (rd_data[7:0] !== held || rd_valid !== 2'b00) begin
        failures++;
        $display("FAIL hold_cycle%0d: got data=%h valid=%b, want data=%h valid=00", i, rd_data[7:0], rd_valid, held);
      end
    end
    idle();
    rd_en = 2'b01;
    step();
    idle();
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (rd_data[7:0] !== e.data || rd_valid[0] !== 1'b1) begin
        failures++;
        $display("FAIL hold_reread: got data=%h valid=%b, want data=%h valid=1", rd_data[7:0], rd_valid[0], e.data);
      end
    end
  endtask

`ifdef REGFILE_ZERO_REG_EN
  task automatic test_zero_reg();
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) begin
        wr_en = 2'b11; wr_addr = {2'd0, 2'd0}; wr_data = {8'hFF, 8'hFF};
      end else begin
        wr_en = 2'b00;
      end
      rd_en = 2'b11; rd_addr = {2'd0, 2'd0};
      step();
      idle();
      checks++;
      if (wr_collision !== (c == 0)) begin
        failures++; $display("FAIL zero_reg_collision%0d: got %b want %b", c, wr_collision, c == 0);
      end
      while (sb.size() > 0) begin
        e = sb.pop_front(); checks++;
        if (rd_data[e.port*8 +: 8] !== 8'h00 || rd_valid[e.port] !== 1'b1) begin
          failures++;
          $display("FAIL zero_reg%0d port%0d: got data=%h valid=%b, want data=00 valid=1", c, e.port, rd_data[e.port*8 +: 8], rd_valid[e.port]);
        end
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    exp_t       e;
    logic       exp_col;
    logic [1:0] en_prev;
    for (int i = 0; i < 60; i++) begin
      rd_en   = 2'($urandom_range(0, 3));
      rd_addr = 4'($urandom_range(0, 15));
      wr_en   = 2'($urandom_range(0, 3));
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = 16'($urandom);
      exp_col = wr_en[0] & wr_en[1] & (wr_addr[1:0] == wr_addr[3:2]);
      en_prev = rd_en;
      step();
      checks++;
      if (wr_collision !== exp_col || rd_valid !== en_prev) begin
        failures++;
        $display("FAIL b2b%0d_flags: got col=%b valid=%b, want col=%b valid=%b", i, wr_collision, rd_valid, exp_col, en_prev);
      end
      while (sb.size() > 0) begin
        e = sb.pop_front(); checks++;
        if (rd_data[e.port*8 +: 8] !== e.data) begin
          failures++;
          $display("FAIL b2b%0d port%0d: got data=%h, want data=%h", i, e.port, rd_data[e.port*8 +: 8], e.data);
        end
      end
    end
    idle();
  endtask

  initial begin
    checks = 0; failures = 0;
    async_rst = 1'b1;
    rd_en = 2'b00; rd_addr = 4'h0; wr_en = 2'b00; wr_addr = 4'h0; wr_data = 16'h0;
    test_reset();
    test_write_read();
    test_bypass();
    test_collision();
    test_hold();
`ifdef REGFILE_ZERO_REG_EN
    test_zero_reg();
`endif
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
